msrv32_imm_packer: RTL

Inverse of the decode-side immediate extraction: takes a 32-bit immediate, an immediate type code and a base instruction word, and packs the immediate into the type-specific instruction bit fields. Output is a complete 32-bit RV32I instruction.
- Range/alignment violations are flagged.
- Sits in the debug program-buffer / instruction-injection path, feeding the fetch mux.
- Registered, single-stage pipeline with valid/ready handshake and a skid buffer, giving full throughput under backpressure.

---
 rtl/msrv32_imm_pkg.sv | 27 ++
 rtl/msrv32_imm_range_chk.sv | 29 ++
 rtl/msrv32_imm_packer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/msrv32_imm_pkg.sv
// Shared definitions for the immediate packer and its range checker:
// immediate type codes and output-stage state encodings.
package msrv32_imm_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_I_ALT = 3'd1;
  localparam logic [2:0] IMM_S     = 3'd2;
  localparam logic [2:0] IMM_B     = 3'd3;
  localparam logic [2:0] IMM_U     = 3'd4;
  localparam logic [2:0] IMM_J     = 3'd5;
  localparam logic [2:0] IMM_CSR   = 3'd6;
  localparam logic [2:0] IMM_I_SYS = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } out_state_e;

  // Three codes share the I-type 12-bit signed layout.
  function automatic logic imm_type_is_i(input logic [2:0] t);
    return (t == IMM_I) || (t == IMM_I_ALT) || (t == IMM_I_SYS);
  endfunction

endpackage

// File: rtl/msrv32_imm_range_chk.sv
// Combinational check that an immediate is representable (range and
// alignment) in the instruction field of the given type.
module msrv32_imm_range_chk
  import msrv32_imm_pkg::*;
(
  input  logic signed [DATA_W-1:0] imm,
  input  logic        [2:0]        imm_type,
  output logic                     range_err
);

  logic [DATA_W-1:0] imm_u;
  assign imm_u = imm;

  always_comb begin
    range_err = 1'b0;
    if (imm_type_is_i(imm_type) || (imm_type == IMM_S)) begin
      range_err = (imm_u[31:11] != {21{imm_u[31]}});
    end else begin
      case (imm_type)
        IMM_B:   range_err = (imm_u[31:12] != {20{imm_u[31]}}) || imm_u[0];
        IMM_U:   range_err = (imm_u[11:0] != 12'd0);
        IMM_J:   range_err = (imm_u[31:20] != {12{imm_u[31]}}) || imm_u[0];
        IMM_CSR: range_err = (imm_u[31:5] != 27'd0);
        default: range_err = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/msrv32_imm_packer.sv
// Packs an immediate into an RV32I instruction word with a registered,
// skid-buffered valid/ready output. Optional error counter: MSRV32_IMM_PACK_ERRCNT_EN.
module msrv32_imm_packer
  import msrv32_imm_pkg::*;
`ifdef MSRV32_IMM_PACK_ERRCNT_EN
#(
  parameter int ERRCNT_W = 16
)
`endif
(
  input  logic                ms_riscv32_mp_clk_in,
  input  logic                ms_riscv32_mp_rst_in,
  input  logic                in_valid_in,
  output logic                in_ready_out,
  input  logic signed [31:0]  imm_in,
  input  logic        [2:0]   imm_type_in,
  input  logic        [31:0]  base_instr_in,
  output logic                out_valid_out,
  input  logic                out_ready_in,
  output logic        [31:0]  instr_out,
`ifdef MSRV32_IMM_PACK_ERRCNT_EN
  output logic [ERRCNT_W-1:0] err_count_out,
  input  logic                err_clr_in,
`endif
  output logic                range_err_out
);

  function automatic logic [31:0] pack_instr(input logic [31:0] imm,
                                             input logic [2:0]  t,
                                             input logic [31:0] base);
    logic [31:0] w;
    w = base;
    case (t)
      IMM_S: begin
        w[31:25] = imm[11:5];
        w[11:7]  = imm[4:0];
      end
      IMM_B: begin
        w[31]    = imm[12];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
        w[7]     = imm[11];
      end
      IMM_U:   w[31:12] = imm[31:12];
      IMM_J: begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
      IMM_CSR: w[19:15] = imm[4:0];
      default: w[31:20] = imm[11:0];
    endcase
    return w;
  endfunction

  out_state_e  state_q, state_d;
  logic        load_out, load_skid, pop_skid;
  logic        accept, fire;
  logic [31:0] pack_word_p0;
  logic        pack_err_p0;
  logic [31:0] instr_p1, instr_skid_p1;
  logic        err_p1, err_skid_p1;
  logic        vld_p1;

  // ---- stage p0: combinational pack and range check of the request
  assign pack_word_p0 = pack_instr(imm_in, imm_type_in, base_instr_in);

  msrv32_imm_range_chk u_range_chk (
    .imm       (imm_in),
    .imm_type  (imm_type_in),
    .range_err (pack_err_p0)
  );

  assign vld_p1        = (state_q != ST_EMPTY);
  assign in_ready_out  = (state_q != ST_SKID);
  assign out_valid_out = vld_p1;
  assign instr_out     = instr_p1;
  assign range_err_out = err_p1;
  assign accept        = in_valid_in && in_ready_out;
  assign fire          = vld_p1 && out_ready_in;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d  = ST_FULL;
          load_out = 1'b1;
        end
      end
      ST_FULL: begin
        if (accept && fire) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = ST_SKID;
          load_skid = 1'b1;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        // Input is stalled here, so only the drain path can move.
        if (fire) begin
          state_d  = ST_FULL;
          pop_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // ---- stage p1: output register and skid buffer
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      instr_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (load_out) begin
      instr_p1 <= pack_word_p0;
      err_p1   <= pack_err_p0;
    end else if (pop_skid) begin
      instr_p1 <= instr_skid_p1;
      err_p1   <= err_skid_p1;
    end
  end

  // Skid contents are only meaningful while state_q says SKID.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (load_skid) begin
      instr_skid_p1 <= pack_word_p0;
      err_skid_p1   <= pack_err_p0;
    end
  end

`ifdef MSRV32_IMM_PACK_ERRCNT_EN
  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [ERRCNT_W-1:0] err_cnt_q;
  assign err_count_out = err_cnt_q;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in || err_clr_in) begin
      err_cnt_q <= '0;
    end else if (fire && err_p1) begin
      err_cnt_q <= sat_inc(err_cnt_q);
    end
  end
`endif

endmodule
